// File: rtl/tdm_demux1_4.sv
// Receive side of the 4-channel TDM link: steers each word to its channel register and tracks frame alignment.
// Latency 1 cycle from the sampling edge to every output; full rate with no stalls and no back-pressure.
module tdm_demux1_4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [4*WIDTH-1:0]   ch_data,
    output logic [3:0]           ch_valid,
    output logic [4*WIDTH-1:0]   frame_data,
    output logic                 frame_valid,
    output logic [1:0]           slot,
    output logic                 locked,
    output logic                 sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0][WIDTH-1:0]   ch_q, ch_d;
    logic [3:0][WIDTH-1:0]   frame_q, frame_d;
    logic [3:0]              ch_valid_q, ch_valid_d;
    logic                    frame_valid_q, frame_valid_d;
    logic [1:0]              slot_q, slot_d;
    logic                    sync_err_q, sync_err_d;

    logic sync_word;
    logic data_word;

    assign sync_word = din_valid & frame_sync;
    assign data_word = din_valid & ~frame_sync;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a sync word always (re)acquires alignment, a data word in slot 0 loses it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT: begin
                if (sync_word) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (data_word && (slot_q == 2'd0)) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        ch_d          = ch_q;
        frame_d       = frame_q;
        ch_valid_d    = 4'b0000;
        frame_valid_d = 1'b0;
        slot_d        = slot_q;
        sync_err_d    = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (sync_word) begin
                    ch_d[0]       = din;
                    ch_valid_d[0] = 1'b1;
                    slot_d        = 2'd1;
                end
            end
            LOCKED: begin
                if (sync_word) begin
                    // Early sync aborts the partial frame and restarts at channel 0
                    sync_err_d    = (slot_q != 2'd0);
                    ch_d[0]       = din;
                    ch_valid_d[0] = 1'b1;
                    slot_d        = 2'd1;
                end else if (data_word) begin
                    if (slot_q == 2'd0) begin
                        sync_err_d = 1'b1;
                    end else begin
                        ch_d[slot_q]       = din;
                        ch_valid_d[slot_q] = 1'b1;
                        slot_d             = slot_q + 2'd1;
                        if (slot_q == 2'd3) begin
                            frame_d[3]    = din;
                            frame_d[2:0]  = ch_q[2:0];
                            frame_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q          <= '0;
            frame_q       <= '0;
            ch_valid_q    <= 4'b0000;
            frame_valid_q <= 1'b0;
            slot_q        <= 2'd0;
            sync_err_q    <= 1'b0;
        end else begin
            ch_q          <= ch_d;
            frame_q       <= frame_d;
            ch_valid_q    <= ch_valid_d;
            frame_valid_q <= frame_valid_d;
            slot_q        <= slot_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign ch_data     = ch_q;
    assign frame_data  = frame_q;
    assign ch_valid    = ch_valid_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux1_4.sv
// Scoreboard bench for tdm_demux1_4: driver pushes per-cycle expectations from a frame-level model, monitor compares.
module tb_tdm_demux1_4;

    localparam int W = 8;

    logic             clk;
    logic             rst;
    logic [W-1:0]     din;
    logic             din_valid;
    logic             frame_sync;
    logic [4*W-1:0]   ch_data;
    logic [3:0]       ch_valid;
    logic [4*W-1:0]   frame_data;
    logic             frame_valid;
    logic [1:0]       slot;
    logic             locked;
    logic             sync_err;

    tdm_demux1_4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    typedef struct packed {
        logic [4*W-1:0] ch_data;
        logic [3:0]     ch_valid;
        logic [4*W-1:0] frame_data;
        logic           frame_valid;
        logic [1:0]     slot;
        logic           locked;
        logic           sync_err;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: channel words, last frame, alignment position
    logic [W-1:0] m_chan [4];
    logic [W-1:0] m_frame [4];
    int           m_pos;
    bit           m_locked;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t snapshot_dut();
        obs_t o;
        o.ch_data     = ch_data;
        o.ch_valid    = ch_valid;
        o.frame_data  = frame_data;
        o.frame_valid = frame_valid;
        o.slot        = slot;
        o.locked      = locked;
        o.sync_err    = sync_err;
        return o;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got ch=%h chv=%b fr=%h frv=%b slot=%0d lk=%b err=%b, want ch=%h chv=%b fr=%h frv=%b slot=%0d lk=%b err=%b",
                     name, $time, act.ch_data, act.ch_valid, act.frame_data, act.frame_valid, act.slot, act.locked, act.sync_err,
                     exp.ch_data, exp.ch_valid, exp.frame_data, exp.frame_valid, exp.slot, exp.locked, exp.sync_err);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_chan[k]  = '0;
            m_frame[k] = '0;
        end
        m_pos    = 0;
        m_locked = 0;
    endtask

    function automatic obs_t model_step(input bit v, input bit s, input logic [W-1:0] d);
        obs_t e;
        e.ch_valid    = '0;
        e.frame_valid = 1'b0;
        e.sync_err    = 1'b0;
        if (v) begin
            if (s) begin
                if (m_locked && m_pos != 0) e.sync_err = 1'b1;
                m_chan[0]     = d;
                e.ch_valid[0] = 1'b1;
                m_pos         = 1;
                m_locked      = 1;
            end else if (m_locked) begin
                if (m_pos == 0) begin
                    e.sync_err = 1'b1;
                    m_locked   = 0;
                end else begin
                    m_chan[m_pos]     = d;
                    e.ch_valid[m_pos] = 1'b1;
                    if (m_pos == 3) begin
                        for (int k = 0; k < 4; k++) m_frame[k] = m_chan[k];
                        e.frame_valid = 1'b1;
                    end
                    m_pos = (m_pos + 1) % 4;
                end
            end
        end
        e.ch_data    = {m_chan[3], m_chan[2], m_chan[1], m_chan[0]};
        e.frame_data = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
        e.slot       = 2'(m_pos);
        e.locked     = m_locked;
        return e;
    endfunction

    task automatic send(input bit v, input bit s, input logic [W-1:0] d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        exp_q.push_back(model_step(v, s, d));
    endtask

    task automatic word(input logic [W-1:0] d, input bit s);
        send(1'b1, s, d);
    endtask

    task automatic gap();
        send(1'b0, $urandom_range(0, 1) == 1, W'($urandom));
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        obs_t zero;
        @(negedge clk);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        rst        = 1'b1;
        #1;
        zero = '0;
        compare("async_reset", snapshot_dut(), zero);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one observation per clock once the driver has queued an expectation
    always begin
        @(posedge clk);
        #1;
        if (!rst && exp_q.size() > 0) begin
            compare("cycle", snapshot_dut(), exp_q.pop_front());
        end
    end

    initial begin
        obs_t tmp;
        logic [4*W-1:0] fr;
        rst        = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        model_reset();

        // Aligned frame
        do_reset();
        word(8'h11, 1); word(8'h22, 0); word(8'h33, 0); word(8'h44, 0);
        @(posedge clk); #2;
        vectors++;
        fr = frame_data;
        if (fr !== 32'h44332211 || locked !== 1'b1 || slot !== 2'd0) begin
            miscompares++;
            $display("FAIL aligned_frame: got fr=%h lk=%b slot=%0d, want fr=44332211 lk=1 slot=0", fr, locked, slot);
        end

        // Hunt discard
        do_reset();
        word(8'hAA, 0); word(8'hBB, 0); word(8'h11, 1);

        // Gapped input
        do_reset();
        word(8'h11, 1); gap(); word(8'h22, 0); gap(); gap(); word(8'h33, 0); gap(); word(8'h44, 0); gap();

        // Early sync
        do_reset();
        word(8'h11, 1); word(8'h22, 0); word(8'h55, 1);

        // Missing sync
        do_reset();
        word(8'h11, 1); word(8'h22, 0); word(8'h33, 0); word(8'h44, 0); word(8'h66, 0);

        // Reset mid-frame
        do_reset();
        word(8'h11, 1); word(8'h22, 0);
        @(posedge clk); #2;
        do_reset();
        word(8'h33, 0); word(8'h44, 0); gap();

        // Randomised traffic, biased toward well-formed frames
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit v, s;
            r = $urandom_range(0, 99);
            if (r == 0) begin
                @(posedge clk); #2;
                do_reset();
            end else begin
                v = ($urandom_range(0, 99) < 75);
                if (m_pos == 0) s = ($urandom_range(0, 99) < 85);
                else            s = ($urandom_range(0, 99) < 8);
                send(v, s, W'($urandom));
            end
        end

        @(negedge clk);
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        tmp = '0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
